// File: rtl/regfile_scan_checker.sv
// regfile_scan_checker: runs the core for num_cycles, then scans the regfile via port A against an expected-value ROM
module regfile_scan_checker #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 32,
  parameter int REG_AW      = 5,
  parameter int CYCLE_WIDTH = 11,
  parameter bit CHECK_R0    = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [CYCLE_WIDTH-1:0] num_cycles,
  input  logic                   halt_on_fail,
  output logic                   test_mode,
  output logic [REG_AW-1:0]      reg_sel,
  input  logic [DATA_WIDTH-1:0]  reg_data,
  output logic [REG_AW-1:0]      exp_addr,
  input  logic [DATA_WIDTH-1:0]  exp_data,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [REG_AW:0]        error_count,
  output logic                   first_fail_valid,
  output logic [REG_AW-1:0]      first_fail_reg,
  output logic [CYCLE_WIDTH-1:0] cycle_count
);
  typedef enum logic [2:0] {IDLE, RUN, SCAN, DRAIN, DONE} state_t;
  localparam logic [REG_AW-1:0] LAST = REG_AW'(NUM_REGS - 1);
  state_t state_q, state_d;
  logic [CYCLE_WIDTH-1:0] num_q, num_d, cyc_q, cyc_d;
  logic [REG_AW-1:0] sel_q, sel_d, idx_q, idx_d, ffr_q, ffr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [REG_AW:0] err_q, err_d;
  logic halt_q, halt_d, cv_q, cv_d, ffv_q, ffv_d;
  logic go, mis, stop;
  assign go   = start && (state_q == IDLE || state_q == DONE);
  assign mis  = cv_q && data_q != exp_data && (CHECK_R0 || idx_q != '0);
  assign stop = mis && halt_q;
  always_comb begin
    num_d   = go ? num_cycles : num_q;
    halt_d  = go ? halt_on_fail : halt_q;
    cyc_d   = go ? '0 : state_q == RUN ? cyc_q + CYCLE_WIDTH'(1) : cyc_q;
    sel_d   = go ? '0 : (state_q == SCAN && sel_q != LAST && !stop) ? sel_q + REG_AW'(1) : sel_q;
    data_d  = reg_data;
    idx_d   = sel_q;
    cv_d    = state_q == SCAN && !stop;
    err_d   = go ? '0 : (mis && !(&err_q)) ? err_q + (REG_AW+1)'(1) : err_q;
    ffv_d   = go ? 1'b0 : ffv_q | mis;
    ffr_d   = go ? '0 : (mis && !ffv_q) ? idx_q : ffr_q;
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = start ? (num_cycles == '0 ? SCAN : RUN) : state_q;
      RUN:        state_d = cyc_q == num_q - CYCLE_WIDTH'(1) ? SCAN : RUN;
      SCAN:       state_d = stop ? DONE : sel_q == LAST ? DRAIN : SCAN;
      DRAIN:      state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      num_q   <= '0;
      halt_q  <= 1'b0;
      cyc_q   <= '0;
      sel_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      cv_q    <= 1'b0;
      err_q   <= '0;
      ffv_q   <= 1'b0;
      ffr_q   <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      halt_q  <= halt_d;
      cyc_q   <= cyc_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      cv_q    <= cv_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffr_q   <= ffr_d;
    end
  end
  assign test_mode        = state_q == SCAN || state_q == DRAIN;
  assign busy             = state_q == RUN || test_mode;
  assign done             = state_q == DONE;
  assign pass             = done && err_q == '0;
  assign reg_sel          = sel_q;
  assign exp_addr         = sel_q;
  assign error_count      = err_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_reg   = ffr_q;
  assign cycle_count      = cyc_q;
endmodule

// File: tb/tb_regfile_scan_checker.sv
// tb_regfile_scan_checker: randomized self-checking bench for three checker configurations
module tb_regfile_scan_checker;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset;
  logic [2:0] start_v;
  logic [10:0] num_cycles;
  logic halt_on_fail;
  logic [2:0] tm_v, busy_v, done_v, pass_v, ffv_v;
  logic [4:0] sel0, sel1, ea0, ea1, ffr0, ffr1;
  logic [2:0] sel2, ea2, ffr2;
  logic [5:0] err0, err1;
  logic [3:0] err2;
  logic [10:0] cyc0, cyc1, cyc2;
  logic [31:0] rd0, rd1, ed0, ed1;
  logic [15:0] rd2, ed2;
  logic [31:0] rf [3][32];
  logic [31:0] rom [3][32];
  logic [5:0] err_v [3];
  logic [4:0] sel_v [3];
  logic [4:0] ffr_v [3];
  logic [10:0] cyc_v [3];
  int n_checks = 0;
  int n_fail = 0;
  regfile_scan_checker u0 (
    .clock(clock), .reset(reset), .start(start_v[0]), .num_cycles(num_cycles), .halt_on_fail(halt_on_fail),
    .test_mode(tm_v[0]), .reg_sel(sel0), .reg_data(rd0), .exp_addr(ea0), .exp_data(ed0), .busy(busy_v[0]),
    .done(done_v[0]), .pass(pass_v[0]), .error_count(err0), .first_fail_valid(ffv_v[0]),
    .first_fail_reg(ffr0), .cycle_count(cyc0));
  regfile_scan_checker #(.CHECK_R0(1'b0)) u1 (
    .clock(clock), .reset(reset), .start(start_v[1]), .num_cycles(num_cycles), .halt_on_fail(halt_on_fail),
    .test_mode(tm_v[1]), .reg_sel(sel1), .reg_data(rd1), .exp_addr(ea1), .exp_data(ed1), .busy(busy_v[1]),
    .done(done_v[1]), .pass(pass_v[1]), .error_count(err1), .first_fail_valid(ffv_v[1]),
    .first_fail_reg(ffr1), .cycle_count(cyc1));
  regfile_scan_checker #(.DATA_WIDTH(16), .NUM_REGS(8), .REG_AW(3)) u2 (
    .clock(clock), .reset(reset), .start(start_v[2]), .num_cycles(num_cycles), .halt_on_fail(halt_on_fail),
    .test_mode(tm_v[2]), .reg_sel(sel2), .reg_data(rd2), .exp_addr(ea2), .exp_data(ed2), .busy(busy_v[2]),
    .done(done_v[2]), .pass(pass_v[2]), .error_count(err2), .first_fail_valid(ffv_v[2]),
    .first_fail_reg(ffr2), .cycle_count(cyc2));
  assign rd0 = rf[0][sel0];
  assign rd1 = rf[1][sel1];
  assign rd2 = rf[2][sel2][15:0];
  always @(posedge clock) begin
    ed0 <= rom[0][ea0];
    ed1 <= rom[1][ea1];
    ed2 <= rom[2][ea2][15:0];
  end
  assign err_v[0] = err0;
  assign err_v[1] = err1;
  assign err_v[2] = {2'b00, err2};
  assign sel_v[0] = sel0;
  assign sel_v[1] = sel1;
  assign sel_v[2] = {2'b00, sel2};
  assign ffr_v[0] = ffr0;
  assign ffr_v[1] = ffr1;
  assign ffr_v[2] = {2'b00, ffr2};
  assign cyc_v[0] = cyc0;
  assign cyc_v[1] = cyc1;
  assign cyc_v[2] = cyc2;
  function automatic int nregs_of(input int k);
    return k == 2 ? 8 : 32;
  endfunction
  function automatic void model(input int k, input bit halt, input bit chk0, output int errs, output int first);
    logic [31:0] mask;
    mask = k == 2 ? 32'h0000_ffff : 32'hffff_ffff;
    errs = 0;
    first = -1;
    for (int i = 0; i < nregs_of(k); i++)
      if (((rf[k][i] ^ rom[k][i]) & mask) != 0 && (chk0 || i != 0)) begin
        if (first < 0) first = i;
        errs++;
        if (halt) break;
      end
  endfunction
  task automatic fill(input int k, input int ncorrupt);
    int idx;
    int b;
    for (int i = 0; i < 32; i++) begin
      rf[k][i] = $urandom;
      rom[k][i] = rf[k][i];
    end
    repeat (ncorrupt) begin
      idx = $urandom_range(nregs_of(k) - 1, 0);
      b = $urandom_range(k == 2 ? 15 : 31, 0);
      rom[k][idx] = rom[k][idx] ^ (32'h1 << b);
    end
  endtask
  task automatic run(input int k, input int n, input bit halt, output int lat, output int tm_cnt,
                     output int max_sel, output int first_tm);
    lat = -1;
    tm_cnt = 0;
    max_sel = -1;
    first_tm = -1;
    @(negedge clock);
    num_cycles = 11'(n);
    halt_on_fail = halt;
    start_v[k] = 1'b1;
    for (int e = 1; e <= 3000; e++) begin
      @(posedge clock);
      #1;
      start_v[k] = 1'b0;
      if (tm_v[k]) begin
        tm_cnt++;
        if (first_tm < 0) first_tm = e;
        if (int'(sel_v[k]) > max_sel) max_sel = int'(sel_v[k]);
      end
      if (done_v[k]) begin
        lat = e;
        break;
      end
    end
  endtask
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    n_checks++; if ({tm_v, busy_v, done_v, pass_v, ffv_v} !== 15'd0) begin n_fail++; $display("FAIL reset_flags got %b expected 0", {tm_v, busy_v, done_v, pass_v, ffv_v}); end
    n_checks++; if ({err0, sel0, ea0, ffr0, cyc0} !== 32'd0) begin n_fail++; $display("FAIL reset_vectors got %h expected 0", {err0, sel0, ea0, ffr0, cyc0}); end
    @(negedge clock);
    reset = 1'b0;
  endtask
  task automatic test_clean_run();
    int lat, tmc, ms, ft;
    fill(0, 0);
    run(0, 10, 1'b0, lat, tmc, ms, ft);
    n_checks++; if (lat !== 44) begin n_fail++; $display("FAIL clean_latency got %0d expected 44", lat); end
    n_checks++; if (tmc !== 33) begin n_fail++; $display("FAIL clean_test_mode_cycles got %0d expected 33", tmc); end
    n_checks++; if (cyc0 !== 11'd10) begin n_fail++; $display("FAIL clean_cycle_count got %0d expected 10", cyc0); end
    n_checks++; if (pass_v[0] !== 1'b1) begin n_fail++; $display("FAIL clean_pass got %b expected 1", pass_v[0]); end
    n_checks++; if (err0 !== 6'd0) begin n_fail++; $display("FAIL clean_errors got %0d expected 0", err0); end
  endtask
  task automatic test_corrupt(input bit halt);
    int lat, tmc, ms, ft;
    fill(0, 0);
    rf[0][5] = 32'd9;
    rom[0][5] = 32'd7;
    rom[0][20] = ~rf[0][20];
    run(0, 10, halt, lat, tmc, ms, ft);
    n_checks++; if (err0 !== (halt ? 6'd1 : 6'd2)) begin n_fail++; $display("FAIL corrupt_errors halt=%0d got %0d expected %0d", halt, err0, halt ? 1 : 2); end
    n_checks++; if (ffr0 !== 5'd5 || ffv_v[0] !== 1'b1) begin n_fail++; $display("FAIL corrupt_first got %0d/%b expected 5/1", ffr0, ffv_v[0]); end
    n_checks++; if (pass_v[0] !== 1'b0) begin n_fail++; $display("FAIL corrupt_pass got %b expected 0", pass_v[0]); end
    n_checks++; if (lat !== (halt ? 18 : 44)) begin n_fail++; $display("FAIL corrupt_latency halt=%0d got %0d expected %0d", halt, lat, halt ? 18 : 44); end
    if (halt) begin
      n_checks++; if (ms !== 6) begin n_fail++; $display("FAIL halt_max_reg_sel got %0d expected 6", ms); end
    end
  endtask
  task automatic test_no_r0();
    int lat, tmc, ms, ft;
    fill(1, 0);
    rom[1][0] = ~rf[1][0];
    run(1, 0, 1'b0, lat, tmc, ms, ft);
    n_checks++; if (pass_v[1] !== 1'b1 || err1 !== 6'd0) begin n_fail++; $display("FAIL no_r0_result got pass=%b err=%0d expected pass=1 err=0", pass_v[1], err1); end
    n_checks++; if (ffv_v[1] !== 1'b0) begin n_fail++; $display("FAIL no_r0_first_valid got %b expected 0", ffv_v[1]); end
    n_checks++; if (ft !== 1) begin n_fail++; $display("FAIL zero_cycles_scan_entry got %0d expected 1", ft); end
    n_checks++; if (cyc1 !== 11'd0) begin n_fail++; $display("FAIL zero_cycles_count got %0d expected 0", cyc1); end
    n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL zero_cycles_latency got %0d expected 34", lat); end
  endtask
  task automatic test_reset_mid();
    int lat, tmc, ms, ft;
    bit hit;
    fill(0, 2);
    @(negedge clock);
    num_cycles = 11'd3;
    halt_on_fail = 1'b0;
    start_v[0] = 1'b1;
    @(negedge clock);
    start_v[0] = 1'b0;
    hit = 1'b0;
    for (int e = 0; e < 200 && !hit; e++) begin
      if (tm_v[0] && sel0 == 5'd12) hit = 1'b1;
      else @(negedge clock);
    end
    n_checks++; if (!hit) begin n_fail++; $display("FAIL reset_mid_reach got reg_sel=%0d expected 12", sel0); end
    reset = 1'b1;
    @(posedge clock);
    #1;
    n_checks++; if ({tm_v[0], busy_v[0], done_v[0], pass_v[0], ffv_v[0]} !== 5'd0) begin n_fail++; $display("FAIL reset_mid_flags got %b expected 0", {tm_v[0], busy_v[0], done_v[0], pass_v[0], ffv_v[0]}); end
    n_checks++; if ({err0, sel0, ffr0, cyc0} !== 27'd0) begin n_fail++; $display("FAIL reset_mid_vectors got %h expected 0", {err0, sel0, ffr0, cyc0}); end
    @(negedge clock);
    reset = 1'b0;
    fill(0, 0);
    run(0, 10, 1'b0, lat, tmc, ms, ft);
    n_checks++; if (lat !== 44 || pass_v[0] !== 1'b1 || err0 !== 6'd0) begin n_fail++; $display("FAIL reset_mid_rerun got lat=%0d pass=%b err=%0d expected 44/1/0", lat, pass_v[0], err0); end
  endtask
  task automatic test_small();
    int lat, tmc, ms, ft, idx;
    fill(2, 0);
    idx = $urandom_range(7, 0);
    rom[2][idx] = rom[2][idx] ^ 32'h0000_8000;
    run(2, 5, 1'b0, lat, tmc, ms, ft);
    n_checks++; if (tmc !== 9) begin n_fail++; $display("FAIL small_test_mode_cycles got %0d expected 9", tmc); end
    n_checks++; if (err2 !== 4'd1 || ffr2 !== 3'(idx)) begin n_fail++; $display("FAIL small_bit15 got err=%0d first=%0d expected 1/%0d", err2, ffr2, idx); end
    n_checks++; if (lat !== 15 || pass_v[2] !== 1'b0) begin n_fail++; $display("FAIL small_done got lat=%0d pass=%b expected 15/0", lat, pass_v[2]); end
  endtask
  task automatic test_back_to_back();
    int lat, tmc, ms, ft, k, n, errs, first, exp_lat;
    bit halt;
    for (int it = 0; it < 10; it++) begin
      k = (it % 2 == 0) ? 0 : 2;
      n = $urandom_range(15, 0);
      halt = 1'($urandom_range(1, 0));
      fill(k, $urandom_range(3, 0));
      model(k, halt, 1'b1, errs, first);
      exp_lat = (halt && first >= 0) ? n + first + 3 : n + nregs_of(k) + 2;
      run(k, n, halt, lat, tmc, ms, ft);
      n_checks++; if (lat !== exp_lat) begin n_fail++; $display("FAIL rand_latency it=%0d got %0d expected %0d", it, lat, exp_lat); end
      n_checks++; if (int'(err_v[k]) !== errs) begin n_fail++; $display("FAIL rand_errors it=%0d got %0d expected %0d", it, err_v[k], errs); end
      n_checks++; if (ffv_v[k] !== (first >= 0)) begin n_fail++; $display("FAIL rand_first_valid it=%0d got %b expected %b", it, ffv_v[k], first >= 0); end
      n_checks++; if (int'(ffr_v[k]) !== (first < 0 ? 0 : first)) begin n_fail++; $display("FAIL rand_first_reg it=%0d got %0d expected %0d", it, ffr_v[k], first); end
      n_checks++; if (pass_v[k] !== (errs == 0)) begin n_fail++; $display("FAIL rand_pass it=%0d got %b expected %b", it, pass_v[k], errs == 0); end
      n_checks++; if (int'(cyc_v[k]) !== n) begin n_fail++; $display("FAIL rand_cycle_count it=%0d got %0d expected %0d", it, cyc_v[k], n); end
    end
  endtask
  initial begin
    start_v = 3'b000;
    num_cycles = '0;
    halt_on_fail = 1'b0;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 32; i++) begin
        rf[k][i] = '0;
        rom[k][i] = '0;
      end
    test_reset();
    test_clean_run();
    test_corrupt(1'b0);
    test_corrupt(1'b1);
    test_no_r0();
    test_reset_mid();
    test_small();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
